// File: rtl/class_argmax.sv
// Argmax classifier head: captures one score vector, scans it one score per cycle with a
// signed compare, and returns the index/value of the largest score. Optional: CLASS_ARGMAX_THRESH_EN.
module class_argmax #(
    parameter int NUM_CLASSES = 128,
    parameter int DATA_WIDTH  = 8,
    parameter int IDX_WIDTH   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH*NUM_CLASSES-1:0] in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [IDX_WIDTH-1:0]              class_idx,
    output logic [DATA_WIDTH-1:0]             max_score
`ifdef CLASS_ARGMAX_THRESH_EN
    ,
    input  logic [DATA_WIDTH-1:0]             thresh,
    output logic                              defect
`endif
);

    // state | meaning
    // IDLE  | waiting for a score vector (in_ready=1)
    // SCAN  | reading buffer[cnt] into score_q and comparing the previous score against best
    // DONE  | result presented on out_valid until the consumer takes it
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam int CNT_W = IDX_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(NUM_CLASSES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CLASSES - 1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   vec_q [NUM_CLASSES];
    logic [DATA_WIDTH-1:0]   score_q;
    logic [DATA_WIDTH-1:0]   best_q, best_d;
    logic [IDX_WIDTH-1:0]    best_idx_q, best_idx_d;
    logic [DATA_WIDTH-1:0]   max_q, max_d;
    logic [IDX_WIDTH-1:0]    cls_q, cls_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pipe_vld_q, pipe_vld_d;
    logic                    accept;
    logic                    load_score;
    logic                    cmp_gt;
    logic [CNT_W-1:0]        cmp_full;
    logic [IDX_WIDTH-1:0]    rd_idx;
    logic [IDX_WIDTH-1:0]    cmp_idx;

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign class_idx  = cls_q;
    assign max_score  = max_q;
    assign accept     = in_valid && in_ready;
    assign load_score = (state_q == SCAN) && (cnt_q < CNT_END);
    assign rd_idx     = cnt_q[IDX_WIDTH-1:0];
    // score_q lags the read counter by one, so it holds the score at index cnt_q-1
    assign cmp_full   = cnt_q - CNT_W'(1);
    assign cmp_idx    = cmp_full[IDX_WIDTH-1:0];
    assign cmp_gt     = $signed(score_q) > $signed(best_q);

    always_comb begin
        state_d    = state_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        max_d      = max_q;
        cls_d      = cls_q;
        cnt_d      = cnt_q;
        pipe_vld_d = pipe_vld_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    best_d     = in_data[DATA_WIDTH-1:0];
                    best_idx_d = '0;
                    cnt_d      = CNT_W'(1);
                    pipe_vld_d = 1'b0;
                    if (NUM_CLASSES == 1) begin
                        state_d = DONE;
                        cls_d   = '0;
                        max_d   = in_data[DATA_WIDTH-1:0];
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (load_score) begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    pipe_vld_d = 1'b1;
                end
                if (pipe_vld_q) begin
                    if (cmp_gt) begin
                        best_d     = score_q;
                        best_idx_d = cmp_idx;
                    end
                    if (cmp_full == CNT_LAST) begin
                        state_d = DONE;
                        cls_d   = cmp_gt ? cmp_idx : best_idx_q;
                        max_d   = cmp_gt ? score_q : best_q;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            best_q     <= '0;
            best_idx_q <= '0;
            max_q      <= '0;
            cls_q      <= '0;
            cnt_q      <= '0;
            pipe_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            max_q      <= max_d;
            cls_q      <= cls_d;
            cnt_q      <= cnt_d;
            pipe_vld_q <= pipe_vld_d;
        end
    end

    // Datapath storage needs no reset: it is only read after an accept has loaded it
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                vec_q[k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (load_score) score_q <= vec_q[rd_idx];
    end

`ifdef CLASS_ARGMAX_THRESH_EN
    logic [DATA_WIDTH-1:0] thresh_q, thresh_d;
    logic                  defect_q, defect_d;
    logic [DATA_WIDTH-1:0] thresh_eff;

    assign defect     = defect_q;
    assign thresh_eff = accept ? thresh : thresh_q;

    always_comb begin
        thresh_d = thresh_q;
        defect_d = defect_q;
        if (accept) thresh_d = thresh;
        if (state_q != DONE && state_d == DONE) begin
            defect_d = $signed(max_d) > $signed(thresh_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thresh_q <= '0;
            defect_q <= 1'b0;
        end else begin
            thresh_q <= thresh_d;
            defect_q <= defect_d;
        end
    end
`endif

endmodule

// File: tb/tb_class_argmax.sv
// Directed bench for class_argmax with NUM_CLASSES=4, DATA_WIDTH=8; covers the threshold
// output too when CLASS_ARGMAX_THRESH_EN is defined.
module tb_class_argmax;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  class_idx;
    logic [7:0]  max_score;
`ifdef CLASS_ARGMAX_THRESH_EN
    logic [7:0]  thresh;
    logic        defect;
    logic        exp_defect;
`endif

    int n_cmp = 0;
    int n_err = 0;

    class_argmax #(.NUM_CLASSES(4), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .class_idx (class_idx),
        .max_score (max_score)
`ifdef CLASS_ARGMAX_THRESH_EN
        ,
        .thresh    (thresh),
        .defect    (defect)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Offer vector v, expect the result exactly 4 cycles after the accept edge, then consume it.
    task automatic run_vec(input string tag, input logic [31:0] v,
                           input logic [31:0] exp_idx, input logic [31:0] exp_max);
        int waitc;
        int cyc;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            step();
            waitc++;
        end
        check({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = v;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = ~v;
        check({tag, "_scan_busy"}, 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd4);
        check({tag, "_idx"}, 32'(class_idx), exp_idx);
        check({tag, "_max"}, 32'(max_score), exp_max);
`ifdef CLASS_ARGMAX_THRESH_EN
        check({tag, "_defect"}, 32'(defect), 32'(exp_defect));
`endif
        step();
        check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef CLASS_ARGMAX_THRESH_EN
        thresh     = 8'h7F;
        exp_defect = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_class_idx", 32'(class_idx), 32'd0);
        check("rst_max_score", 32'(max_score), 32'd0);

        run_vec("basic", 32'h02107F05, 32'd1, 32'h7F);
        run_vec("all_neg", 32'h90FFF080, 32'd2, 32'hFF);
        run_vec("signed", 32'h800001FF, 32'd1, 32'h01);
        run_vec("ties", 32'h20102020, 32'd0, 32'h20);

        // Backpressure: result held for 5 cycles while a new vector waits on in_valid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h08070903;
        step();
        in_data = 32'h40302010;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check("bp_latency", 32'(cyc), 32'd4);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_class_idx", 32'(class_idx), 32'd1);
            check("bp_max_score", 32'(max_score), 32'h09);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_hs_vld_drop", 32'(out_valid), 32'd0);
        check("bp_hs_rdy_back", 32'(in_ready), 32'd1);
        run_vec("after_bp", 32'h40302010, 32'd3, 32'h40);

        // Reset on the second SCAN cycle discards the pending result
        in_valid = 1'b1;
        in_data  = 32'h01020304;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_class_idx", 32'(class_idx), 32'd0);
        check("midrst_max_score", 32'(max_score), 32'd0);
        for (int i = 0; i < 5; i++) step();
        check("midrst_no_result", 32'(out_valid), 32'd0);
        run_vec("fresh", 32'h04030201, 32'd3, 32'h04);

`ifdef CLASS_ARGMAX_THRESH_EN
        thresh     = 8'h40;
        exp_defect = 1'b1;
        run_vec("thr40", 32'h00413010, 32'd2, 32'h41);
        thresh     = 8'h41;
        exp_defect = 1'b0;
        run_vec("thr41", 32'h00413010, 32'd2, 32'h41);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
